// File: rtl/serial_frame_tx.sv
// serial_frame_tx: shifts out a frame onto a single idle-high line.
// The frame is a start bit, then the port field, the count field and N data
// bits, each sent MSB-first.
// Optional parity bit: define TX_PARITY_EN to append an even-parity bit
// after the data bits.
module serial_frame_tx #(
  parameter int CNT_W  = 4,
  parameter int PORT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,          // async, active low
  input  logic                  Start,
  input  logic                  BitEn,
  input  logic [PORT_W-1:0]     PortSel,
  input  logic [CNT_W-1:0]      DataCnt,
  input  logic [2**CNT_W-2:0]   DataIn,
  output logic                  SerOut,
  output logic                  SerOutValid,
  output logic                  Busy,
  output logic                  Done
);

  localparam int DW   = 2**CNT_W - 1;
  localparam int BC_W = (PORT_W > CNT_W) ? PORT_W : CNT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PORT,
    S_CNT,
    S_DATA
`ifdef TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [PORT_W-1:0] port_sh_q, port_sh_d;
  logic [CNT_W-1:0]  cnt_sh_q, cnt_sh_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [DW-1:0]     data_sh_q, data_sh_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic              ser_q, ser_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TX_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              end_payload;
  logic              end_frame;

  // Next-state and output logic. The field shift registers always present
  // the next bit to send at their MSB. The payload is left-aligned at
  // accept time so that bit N-1 lands at the MSB of the data register.
  always_comb begin
    state_d     = state_q;
    port_sh_d   = port_sh_q;
    cnt_sh_d    = cnt_sh_q;
    n_d         = n_q;
    data_sh_d   = data_sh_q;
    bitcnt_d    = bitcnt_q;
    ser_d       = ser_q;
    vld_d       = vld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef TX_PARITY_EN
    par_d       = par_q;
`endif
    end_payload = 1'b0;
    end_frame   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          port_sh_d = PortSel;
          cnt_sh_d  = DataCnt;
          n_d       = DataCnt;
          data_sh_d = DataIn << (DW - int'(DataCnt));
`ifdef TX_PARITY_EN
          par_d     = 1'b0;
`endif
          state_d   = S_START;
          ser_d     = 1'b0;
          busy_d    = 1'b1;
          vld_d     = 1'b0;
        end
      end
      S_START: begin
        if (BitEn) begin
          state_d   = S_PORT;
          ser_d     = port_sh_q[PORT_W-1];
          port_sh_d = port_sh_q << 1;
          bitcnt_d  = BC_W'(PORT_W - 1);
        end
      end
      S_PORT: begin
        if (BitEn) begin
          if (bitcnt_q == '0) begin
            state_d  = S_CNT;
            ser_d    = cnt_sh_q[CNT_W-1];
            cnt_sh_d = cnt_sh_q << 1;
            bitcnt_d = BC_W'(CNT_W - 1);
          end else begin
            ser_d     = port_sh_q[PORT_W-1];
            port_sh_d = port_sh_q << 1;
            bitcnt_d  = bitcnt_q - BC_W'(1);
          end
        end
      end
      S_CNT: begin
        if (BitEn) begin
          if (bitcnt_q == '0) begin
            if (n_q != '0) begin
              state_d   = S_DATA;
              ser_d     = data_sh_q[DW-1];
              data_sh_d = data_sh_q << 1;
              vld_d     = 1'b1;
              bitcnt_d  = BC_W'(n_q - CNT_W'(1));
`ifdef TX_PARITY_EN
              par_d     = par_q ^ data_sh_q[DW-1];
`endif
            end else begin
              end_payload = 1'b1;
            end
          end else begin
            ser_d    = cnt_sh_q[CNT_W-1];
            cnt_sh_d = cnt_sh_q << 1;
            bitcnt_d = bitcnt_q - BC_W'(1);
          end
        end
      end
      S_DATA: begin
        if (BitEn) begin
          if (bitcnt_q == '0) begin
            end_payload = 1'b1;
          end else begin
            ser_d     = data_sh_q[DW-1];
            data_sh_d = data_sh_q << 1;
            bitcnt_d  = bitcnt_q - BC_W'(1);
`ifdef TX_PARITY_EN
            par_d     = par_q ^ data_sh_q[DW-1];
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        if (BitEn) end_frame = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // After the payload (or straight after the count field when N=0),
    // either send the parity bit or close the frame.
    if (end_payload) begin
`ifdef TX_PARITY_EN
      state_d = S_PAR;
      ser_d   = par_q;
      vld_d   = 1'b0;
`else
      end_frame = 1'b1;
`endif
    end

    if (end_frame) begin
      state_d = S_IDLE;
      ser_d   = 1'b1;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      port_sh_q <= '0;
      cnt_sh_q  <= '0;
      n_q       <= '0;
      data_sh_q <= '0;
      bitcnt_q  <= '0;
      ser_q     <= 1'b1;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      port_sh_q <= port_sh_d;
      cnt_sh_q  <= cnt_sh_d;
      n_q       <= n_d;
      data_sh_q <= data_sh_d;
      bitcnt_q  <= bitcnt_d;
      ser_q     <= ser_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign SerOut      = ser_q;
  assign SerOutValid = vld_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frames with hand-computed bit sequences.
module tb_serial_frame_tx;

`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Start = 1'b0;
  logic        BitEn = 1'b0;
  logic [1:0]  PortSel = '0;
  logic [3:0]  DataCnt = '0;
  logic [14:0] DataIn = '0;
  logic        SerOut, SerOutValid, Busy, Done;

  int total = 0;
  int bad   = 0;

  serial_frame_tx #(.CNT_W(4), .PORT_W(2)) dut (
    .clk(clk), .rst(rst), .Start(Start), .BitEn(BitEn),
    .PortSel(PortSel), .DataCnt(DataCnt), .DataIn(DataIn),
    .SerOut(SerOut), .SerOutValid(SerOutValid), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame. bits/vmask hold the expected line and valid values,
  // first bit at index nbits-1, parity bit already appended if enabled.
  task automatic send(input string tag, input logic [1:0] ps, input logic [3:0] dc,
                      input logic [14:0] di, input int period, input int nbits,
                      input logic [31:0] bits, input logic [31:0] vmask, input bit pester);
    @(negedge clk);
    PortSel = ps; DataCnt = dc; DataIn = di; Start = 1'b1; BitEn = (period == 1);
    @(negedge clk);
    Start = pester;
    if (pester) begin
      PortSel = ~ps; DataIn = ~di; DataCnt = dc + 4'd1;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int h = 0; h < period; h++) begin
        chk($sformatf("%s ser b%0d", tag, i), 32'(SerOut), 32'(bits[nbits-1-i]));
        chk($sformatf("%s vld b%0d", tag, i), 32'(SerOutValid), 32'(vmask[nbits-1-i]));
        if (h == 0) begin
          chk($sformatf("%s busy b%0d", tag, i), 32'(Busy), 32'd1);
          chk($sformatf("%s done b%0d", tag, i), 32'(Done), 32'd0);
        end
        BitEn = (period == 1) || (h == period - 1);
        @(negedge clk);
      end
    end
    Start = 1'b0; BitEn = 1'b0;
    chk({tag, " end ser"},  32'(SerOut), 32'd1);
    chk({tag, " end busy"}, 32'(Busy), 32'd0);
    chk({tag, " end done"}, 32'(Done), 32'd1);
    chk({tag, " end vld"},  32'(SerOutValid), 32'd0);
    @(negedge clk);
    chk({tag, " done clr"}, 32'(Done), 32'd0);
    chk({tag, " idle ser"}, 32'(SerOut), 32'd1);
    @(negedge clk);
    chk({tag, " no 2nd"},   32'(Busy), 32'd0);
    chk({tag, " idle ser2"}, 32'(SerOut), 32'd1);
  endtask

  function automatic logic [31:0] xb(input logic [31:0] b, input logic p);
    return (PB == 1) ? {b[30:0], p} : b;
  endfunction

  function automatic logic [31:0] xv(input logic [31:0] v);
    return (PB == 1) ? (v << 1) : v;
  endfunction

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst ser",  32'(SerOut), 32'd1);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst vld",  32'(SerOutValid), 32'd0);
    rst = 1'b1;
    // BitEn toggling in IDLE does nothing
    BitEn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle biten ser",  32'(SerOut), 32'd1);
    chk("idle biten busy", 32'(Busy), 32'd0);
    BitEn = 1'b0;

    // basic: port 2, N=3, data 101 -> 0 10 0011 101 (+ parity 0)
    send("basic", 2'd2, 4'd3, 15'b101, 1, 10 + PB,
         xb(32'b0100011101, 1'b0), xv(32'b0000000111), 1'b0);
    // parity flavour: data 100 -> parity 1
    send("d100", 2'd2, 4'd3, 15'b100, 1, 10 + PB,
         xb(32'b0100011100, 1'b1), xv(32'b0000000111), 1'b0);
    // empty payload: 0 01 0000 (+ parity 0)
    send("empty", 2'd1, 4'd0, 15'h7FFF, 1, 7 + PB,
         xb(32'b0010000, 1'b0), xv(32'b0), 1'b0);
    // single bit: 0 00 0001 1 (+ parity 1)
    send("one", 2'd0, 4'd1, 15'h7FFF, 1, 8 + PB,
         xb(32'b00000011, 1'b1), xv(32'b00000001), 1'b0);
    // max payload: 0 11 1111 100101100101101 (+ parity 0)
    send("max", 2'd3, 4'd15, 15'h4B2D, 1, 22 + PB,
         xb({10'd0, 1'b0, 2'b11, 4'b1111, 15'h4B2D}, 1'b0),
         xv(32'h7FFF), 1'b0);
    // BitEn every 5th cycle
    send("step5", 2'd2, 4'd3, 15'b101, 5, 10 + PB,
         xb(32'b0100011101, 1'b0), xv(32'b0000000111), 1'b0);
    // Start held high with other inputs changing during the frame
    send("pester", 2'd2, 4'd3, 15'b101, 1, 10 + PB,
         xb(32'b0100011101, 1'b0), xv(32'b0000000111), 1'b1);

    // reset during DATA acts without a clock edge
    @(negedge clk);
    PortSel = 2'd2; DataCnt = 4'd3; DataIn = 15'b101; Start = 1'b1; BitEn = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre-rst vld", 32'(SerOutValid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async ser",  32'(SerOut), 32'd1);
    chk("async busy", 32'(Busy), 32'd0);
    chk("async vld",  32'(SerOutValid), 32'd0);
    chk("async done", 32'(Done), 32'd0);
    @(negedge clk);
    rst = 1'b1; BitEn = 1'b0;
    send("post-rst", 2'd2, 4'd3, 15'b101, 1, 10 + PB,
         xb(32'b0100011101, 1'b0), xv(32'b0000000111), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
